// File: rtl/tag_record_serializer.sv
// -----------------------------------------------------------------------------
// tag_record_serializer
//
// Buffers time-tag records from the tagging engine in a small FIFO and sends
// each one to a byte-wide UART transmitter as a frame:
//     [SYNC_BYTE]  word byte NBYTES-1 ... word byte 0  [XOR of data bytes]
// The stored word is {lost_flag, rec_data}, zero-extended to NBYTES*8 bits.
// lost_flag marks the first record accepted after one or more drops.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset (release synchronously)
//   enable       permits starting a new frame (FIFO writes are not gated)
//   rec_valid    one-cycle strobe qualifying rec_data
//   rec_data     record from the tagging engine
//   tx_dv        one-cycle pulse: UART loads tx_byte
//   tx_byte      byte to transmit, stable from tx_dv until tx_done
//   tx_done      one-cycle pulse from the UART at the end of the stop bit
//   fifo_level   FIFO occupancy
//   overflow     sticky drop indicator
//   drop_count   saturating count of dropped records
//   clr_stats    synchronous clear of overflow and drop_count
//   busy         FSM is not idle
// -----------------------------------------------------------------------------
module tag_record_serializer #(
    parameter int          RECORD_WIDTH = 47,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          SYNC_EN      = 1,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          CHECKSUM_EN  = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          rec_valid,
    input  logic [RECORD_WIDTH-1:0]       rec_data,
    output logic                          tx_dv,
    output logic [7:0]                    tx_byte,
    input  logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    input  logic                          clr_stats,
    output logic                          busy
);

    localparam int NBYTES = (RECORD_WIDTH + 8) / 8;   // ceil((RECORD_WIDTH+1)/8)
    localparam int WORD_W = NBYTES * 8;
    localparam int EW     = RECORD_WIDTH + 1;         // stored entry width
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_SYNC,
        S_DATA,
        S_CSUM,
        S_WAIT
    } state_t;

    // Which kind of byte is in flight while waiting for tx_done.
    typedef enum logic [1:0] {
        SENT_SYNC,
        SENT_DATA,
        SENT_CSUM
    } sent_t;

    // ---------------------------------------------------------------- FIFO --
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [EW-1:0]  head_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    level_reg;
    logic           lost_reg;
    logic           overflow_reg;
    logic [15:0]    drop_reg;

    state_t         state_reg, state_next;

    logic           full;
    logic           push;
    logic           drop;
    logic           pop;

    // Fullness is judged on the level at the start of the cycle, so a pop in
    // the same cycle cannot make room for an incoming record.
    assign full = (level_reg == (PW+1)'(FIFO_DEPTH));
    assign push = rec_valid && !full;
    assign drop = rec_valid && full;
    assign pop  = (state_reg == S_POP);

    // Storage with registered read. The head is re-read every cycle; the
    // entry at rd_ptr is always written at least one edge before the FSM
    // reaches POP, so head_reg is valid whenever POP consumes it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {lost_reg, rec_data};
        end
        head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            lost_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (PW+1)'(1);
                2'b01:   level_reg <= level_reg - (PW+1)'(1);
                default: level_reg <= level_reg;
            endcase

            if (push) begin
                lost_reg <= 1'b0;
            end else if (drop) begin
                lost_reg <= 1'b1;
            end

            // A drop coinciding with a clear counts as the first drop after it.
            if (drop) begin
                overflow_reg <= 1'b1;
                if (clr_stats) begin
                    drop_reg <= 16'd1;
                end else if (drop_reg != 16'hFFFF) begin
                    drop_reg <= drop_reg + 16'd1;
                end
            end else if (clr_stats) begin
                overflow_reg <= 1'b0;
                drop_reg     <= '0;
            end
        end
    end

    // ----------------------------------------------------------------- FSM --
    logic [WORD_W-1:0] word_reg, word_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [7:0]        csum_reg, csum_next;
    logic [7:0]        tx_byte_reg, tx_byte_next;
    sent_t             sent_reg, sent_next;
    logic [WORD_W-1:0] head_word;

    assign head_word = WORD_W'(head_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            word_reg    <= '0;
            idx_reg     <= '0;
            csum_reg    <= '0;
            tx_byte_reg <= '0;
            sent_reg    <= SENT_SYNC;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            idx_reg     <= idx_next;
            csum_reg    <= csum_next;
            tx_byte_reg <= tx_byte_next;
            sent_reg    <= sent_next;
        end
    end

    // tx_byte is loaded on the edge entering SYNC/DATA/CSUM so it is already
    // valid during the tx_dv cycle and stays put through WAIT. The word is
    // shifted left after each data byte, so the next byte is always the top
    // byte of word_reg.
    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        idx_next     = idx_reg;
        csum_next    = csum_reg;
        tx_byte_next = tx_byte_reg;
        sent_next    = sent_reg;

        case (state_reg)
            S_IDLE: begin
                if (enable && (level_reg != '0)) begin
                    state_next = S_POP;
                end
            end
            S_POP: begin
                word_next = head_word;
                idx_next  = '0;
                csum_next = '0;
                if (SYNC_EN != 0) begin
                    state_next   = S_SYNC;
                    tx_byte_next = SYNC_BYTE;
                end else begin
                    state_next   = S_DATA;
                    tx_byte_next = head_word[WORD_W-1 -: 8];
                end
            end
            S_SYNC: begin
                sent_next  = SENT_SYNC;
                state_next = S_WAIT;
            end
            S_DATA: begin
                sent_next  = SENT_DATA;
                csum_next  = csum_reg ^ tx_byte_reg;
                word_next  = word_reg << 8;
                state_next = S_WAIT;
            end
            S_CSUM: begin
                sent_next  = SENT_CSUM;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    case (sent_reg)
                        SENT_SYNC: begin
                            state_next   = S_DATA;
                            tx_byte_next = word_reg[WORD_W-1 -: 8];
                        end
                        SENT_DATA: begin
                            if (idx_reg < IW'(NBYTES-1)) begin
                                idx_next     = idx_reg + IW'(1);
                                state_next   = S_DATA;
                                tx_byte_next = word_reg[WORD_W-1 -: 8];
                            end else if (CHECKSUM_EN != 0) begin
                                state_next   = S_CSUM;
                                tx_byte_next = csum_reg;
                            end else begin
                                state_next = S_IDLE;
                            end
                        end
                        default: begin
                            state_next = S_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tx_dv      = (state_reg == S_SYNC) || (state_reg == S_DATA) ||
                        (state_reg == S_CSUM);
    assign tx_byte    = tx_byte_reg;
    assign busy       = (state_reg != S_IDLE);
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;
    assign drop_count = drop_reg;

endmodule
